// File: rtl/axi_rd_arbiter_2to1.sv
// Two-master to one-slave AXI read arbiter; serialises whole bursts onto the ROM read port.
// Round-robin by default; define RD_ARB_FIXED_PRIO_EN for fixed priority (M0 wins ties).
module axi_rd_arbiter_2to1 #(
    parameter int unsigned ID_BITS   = 4,
    parameter int unsigned ADDR_BITS = 32,
    parameter int unsigned DATA_BITS = 32,
    parameter int unsigned LEN_BITS  = 4
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    // master 0 (instruction fetch)
    input  logic [ID_BITS-1:0]   M0_ARID,
    input  logic [ADDR_BITS-1:0] M0_ARADDR,
    input  logic [LEN_BITS-1:0]  M0_ARLEN,
    input  logic [2:0]           M0_ARSIZE,
    input  logic [1:0]           M0_ARBURST,
    input  logic                 M0_ARVALID,
    output logic                 M0_ARREADY,
    output logic [ID_BITS-1:0]   M0_RID,
    output logic [DATA_BITS-1:0] M0_RDATA,
    output logic [1:0]           M0_RRESP,
    output logic                 M0_RLAST,
    output logic                 M0_RVALID,
    input  logic                 M0_RREADY,
    // master 1 (boot/DMA loader)
    input  logic [ID_BITS-1:0]   M1_ARID,
    input  logic [ADDR_BITS-1:0] M1_ARADDR,
    input  logic [LEN_BITS-1:0]  M1_ARLEN,
    input  logic [2:0]           M1_ARSIZE,
    input  logic [1:0]           M1_ARBURST,
    input  logic                 M1_ARVALID,
    output logic                 M1_ARREADY,
    output logic [ID_BITS-1:0]   M1_RID,
    output logic [DATA_BITS-1:0] M1_RDATA,
    output logic [1:0]           M1_RRESP,
    output logic                 M1_RLAST,
    output logic                 M1_RVALID,
    input  logic                 M1_RREADY,
    // ROM slave
    output logic [ID_BITS-1:0]   S_ARID,
    output logic [ADDR_BITS-1:0] S_ARADDR,
    output logic [LEN_BITS-1:0]  S_ARLEN,
    output logic [2:0]           S_ARSIZE,
    output logic [1:0]           S_ARBURST,
    output logic                 S_ARVALID,
    input  logic                 S_ARREADY,
    input  logic [ID_BITS-1:0]   S_RID,
    input  logic [DATA_BITS-1:0] S_RDATA,
    input  logic [1:0]           S_RRESP,
    input  logic                 S_RLAST,
    input  logic                 S_RVALID,
    output logic                 S_RREADY,
    output logic [1:0]           GRANT
);

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData
    } state_e;

    state_e              r_state, w_state_nxt;
    logic                r_grant, w_grant_nxt;       // 0 = M0, 1 = M1
    logic [LEN_BITS-1:0] r_len, w_len_nxt;
    logic [LEN_BITS-1:0] r_beat_cnt, w_beat_cnt_nxt;
    logic                w_pick;
    logic                w_ar_hs;
    logic                w_r_hs;

`ifndef RD_ARB_FIXED_PRIO_EN
    logic                r_last_grant, w_last_grant_nxt;
`endif

    assign w_ar_hs = (r_state == StAddr) && S_ARVALID && S_ARREADY;
    assign w_r_hs  = (r_state == StData) && S_RVALID && S_RREADY;

    // Tie-break between simultaneous requests
    always_comb begin
        w_pick = M1_ARVALID;
        if (M0_ARVALID && M1_ARVALID) begin
`ifdef RD_ARB_FIXED_PRIO_EN
            w_pick = 1'b0;
`else
            w_pick = ~r_last_grant;
`endif
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_len_nxt      = r_len;
        w_beat_cnt_nxt = r_beat_cnt;
`ifndef RD_ARB_FIXED_PRIO_EN
        w_last_grant_nxt = r_last_grant;
`endif
        case (r_state)
            StIdle: begin
                if (M0_ARVALID || M1_ARVALID) begin
                    w_grant_nxt = w_pick;
`ifndef RD_ARB_FIXED_PRIO_EN
                    w_last_grant_nxt = w_pick;
`endif
                    w_state_nxt = StAddr;
                end
            end
            StAddr: begin
                if (w_ar_hs) begin
                    w_len_nxt      = r_grant ? M1_ARLEN : M0_ARLEN;
                    w_beat_cnt_nxt = '0;
                    w_state_nxt    = StData;
                end
            end
            StData: begin
                if (w_r_hs) begin
                    w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    if (S_RLAST) begin
                        w_state_nxt = StIdle;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state    <= StIdle;
            r_grant    <= 1'b0;
            r_len      <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_len      <= w_len_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

`ifndef RD_ARB_FIXED_PRIO_EN
    // Reset to M1 so that M0 wins the first tie
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_last_grant <= 1'b1;
        end else begin
            r_last_grant <= w_last_grant_nxt;
        end
    end
`endif

    // Channel muxing; everything idles at zero outside the owning phase
    always_comb begin
        S_ARID     = '0;
        S_ARADDR   = '0;
        S_ARLEN    = '0;
        S_ARSIZE   = '0;
        S_ARBURST  = '0;
        S_ARVALID  = 1'b0;
        S_RREADY   = 1'b0;
        M0_ARREADY = 1'b0;
        M0_RID     = '0;
        M0_RDATA   = '0;
        M0_RRESP   = '0;
        M0_RLAST   = 1'b0;
        M0_RVALID  = 1'b0;
        M1_ARREADY = 1'b0;
        M1_RID     = '0;
        M1_RDATA   = '0;
        M1_RRESP   = '0;
        M1_RLAST   = 1'b0;
        M1_RVALID  = 1'b0;
        case (r_state)
            StAddr: begin
                if (r_grant) begin
                    S_ARID     = M1_ARID;
                    S_ARADDR   = M1_ARADDR;
                    S_ARLEN    = M1_ARLEN;
                    S_ARSIZE   = M1_ARSIZE;
                    S_ARBURST  = M1_ARBURST;
                    S_ARVALID  = M1_ARVALID;
                    M1_ARREADY = S_ARREADY;
                end else begin
                    S_ARID     = M0_ARID;
                    S_ARADDR   = M0_ARADDR;
                    S_ARLEN    = M0_ARLEN;
                    S_ARSIZE   = M0_ARSIZE;
                    S_ARBURST  = M0_ARBURST;
                    S_ARVALID  = M0_ARVALID;
                    M0_ARREADY = S_ARREADY;
                end
            end
            StData: begin
                if (r_grant) begin
                    M1_RID    = S_RID;
                    M1_RDATA  = S_RDATA;
                    M1_RRESP  = S_RRESP;
                    M1_RLAST  = S_RLAST;
                    M1_RVALID = S_RVALID;
                    S_RREADY  = M1_RREADY;
                end else begin
                    M0_RID    = S_RID;
                    M0_RDATA  = S_RDATA;
                    M0_RRESP  = S_RRESP;
                    M0_RLAST  = S_RLAST;
                    M0_RVALID = S_RVALID;
                    S_RREADY  = M0_RREADY;
                end
            end
            default: ;
        endcase
    end

    assign GRANT = (r_state == StIdle) ? 2'b00 : (r_grant ? 2'b10 : 2'b01);

    // The beat count only cross-checks the slave; RLAST alone ends the burst
    a_beat_count: assert property (@(posedge ACLK) disable iff (!ARESETn)
        (w_r_hs && S_RLAST) |-> (r_beat_cnt == r_len));

endmodule

// File: tb/tb_axi_rd_arbiter_2to1.sv
// Scoreboard bench for axi_rd_arbiter_2to1: behavioural ROM slave, expected R beats and
// grant order queued at stimulus time and popped when the DUT hands them out.
module tb_axi_rd_arbiter_2to1;

    logic        ACLK;
    logic        ARESETn;
    logic [3:0]  M0_ARID, M1_ARID, S_ARID, M0_RID, M1_RID, S_RID;
    logic [31:0] M0_ARADDR, M1_ARADDR, S_ARADDR;
    logic [3:0]  M0_ARLEN, M1_ARLEN, S_ARLEN;
    logic [2:0]  M0_ARSIZE, M1_ARSIZE, S_ARSIZE;
    logic [1:0]  M0_ARBURST, M1_ARBURST, S_ARBURST;
    logic        M0_ARVALID, M1_ARVALID, S_ARVALID;
    logic        M0_ARREADY, M1_ARREADY, S_ARREADY;
    logic [31:0] M0_RDATA, M1_RDATA, S_RDATA;
    logic [1:0]  M0_RRESP, M1_RRESP, S_RRESP;
    logic        M0_RLAST, M1_RLAST, S_RLAST;
    logic        M0_RVALID, M1_RVALID, S_RVALID;
    logic        M0_RREADY, M1_RREADY, S_RREADY;
    logic [1:0]  GRANT;

    int          n_checks = 0;
    int          n_errors = 0;
    int          stall_cfg = 0;
    logic [38:0] q0[$];
    logic [38:0] q1[$];
    logic [1:0]  gq[$];

    axi_rd_arbiter_2to1 dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .M0_ARID(M0_ARID), .M0_ARADDR(M0_ARADDR), .M0_ARLEN(M0_ARLEN), .M0_ARSIZE(M0_ARSIZE),
        .M0_ARBURST(M0_ARBURST), .M0_ARVALID(M0_ARVALID), .M0_ARREADY(M0_ARREADY),
        .M0_RID(M0_RID), .M0_RDATA(M0_RDATA), .M0_RRESP(M0_RRESP), .M0_RLAST(M0_RLAST),
        .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY),
        .M1_ARID(M1_ARID), .M1_ARADDR(M1_ARADDR), .M1_ARLEN(M1_ARLEN), .M1_ARSIZE(M1_ARSIZE),
        .M1_ARBURST(M1_ARBURST), .M1_ARVALID(M1_ARVALID), .M1_ARREADY(M1_ARREADY),
        .M1_RID(M1_RID), .M1_RDATA(M1_RDATA), .M1_RRESP(M1_RRESP), .M1_RLAST(M1_RLAST),
        .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY),
        .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE),
        .S_ARBURST(S_ARBURST), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
        .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
        .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
        .GRANT(GRANT)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] beat_data(input logic [3:0] id, input logic [31:0] addr,
                                              input int beat);
        if (addr == 32'h10 && beat == 0) return 32'hDEADBEEF;
        return (addr + 32'(beat * 4)) ^ {id, 28'h0};
    endfunction

    function automatic logic [1:0] beat_resp(input int beat);
        return (beat % 2 == 1) ? 2'b01 : 2'b00;
    endfunction

    // Packed as {RID, RRESP, RLAST, RDATA}
    function automatic logic [38:0] exp_beat(input logic [3:0] id, input logic [31:0] addr,
                                             input int beat, input logic [3:0] len);
        logic last;
        last = (beat == int'(len));
        return {id, beat_resp(beat), last, beat_data(id, addr, beat)};
    endfunction

    // Behavioural ROM slave; shares ARESETn with the arbiter
    initial begin : rom_slave
        logic        smp_ar, smp_r, smp_arv;
        logic [3:0]  smp_id, cur_id, cur_len, smp_len;
        logic [31:0] smp_addr, cur_addr;
        logic        busy;
        int          beat, stalled;
        busy = 1'b0; beat = 0; stalled = 0;
        cur_id = '0; cur_addr = '0; cur_len = '0;
        S_ARREADY = 1'b0; S_RVALID = 1'b0; S_RID = '0; S_RDATA = '0; S_RRESP = '0;
        S_RLAST = 1'b0;
        forever begin
            @(negedge ACLK);
            smp_ar   = S_ARVALID && S_ARREADY;
            smp_arv  = S_ARVALID;
            smp_r    = S_RVALID && S_RREADY;
            smp_id   = S_ARID;
            smp_addr = S_ARADDR;
            smp_len  = S_ARLEN;
            @(posedge ACLK);
            #1;
            if (!ARESETn) begin
                busy = 1'b0; beat = 0; stalled = 0;
            end else if (smp_ar) begin
                busy = 1'b1; beat = 0; stalled = 0;
                cur_id = smp_id; cur_addr = smp_addr; cur_len = smp_len;
            end else begin
                if (smp_arv && !busy) stalled++;
                if (smp_r) begin
                    if (beat == int'(cur_len)) busy = 1'b0;
                    else beat++;
                end
            end
            S_ARREADY = ARESETn && !busy && (stalled >= stall_cfg);
            S_RVALID  = busy;
            S_RID     = busy ? cur_id : 4'h0;
            S_RDATA   = busy ? beat_data(cur_id, cur_addr, beat) : 32'h0;
            S_RRESP   = busy ? beat_resp(beat) : 2'b00;
            S_RLAST   = busy && (beat == int'(cur_len));
        end
    end

    initial begin : monitor
        logic [1:0] prev_g;
        prev_g = 2'b00;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                prev_g = 2'b00;
            end else begin
                if (GRANT != prev_g && GRANT != 2'b00) begin
                    if (gq.size() == 0) check_eq("grant_unexp", GRANT, 2'b00);
                    else check_eq("grant_order", GRANT, gq.pop_front());
                end
                prev_g = GRANT;
                if (M0_RVALID && M0_RREADY) begin
                    if (q0.size() == 0) check_eq("r0_unexp", M0_RVALID, 1'b0);
                    else check_eq("r0_beat", {M0_RID, M0_RRESP, M0_RLAST, M0_RDATA},
                                  q0.pop_front());
                end
                if (M1_RVALID && M1_RREADY) begin
                    if (q1.size() == 0) check_eq("r1_unexp", M1_RVALID, 1'b0);
                    else check_eq("r1_beat", {M1_RID, M1_RRESP, M1_RLAST, M1_RDATA},
                                  q1.pop_front());
                end
                if (GRANT != 2'b01) check_eq("m0_not_owner", {M0_ARREADY, M0_RVALID}, 2'b00);
                if (GRANT != 2'b10) check_eq("m1_not_owner", {M1_ARREADY, M1_RVALID}, 2'b00);
                if (GRANT == 2'b00) check_eq("idle_slave", {S_ARVALID, S_RREADY}, 2'b00);
            end
        end
    end

    task automatic drive_ar(input int m, input logic v, input logic [3:0] id,
                            input logic [31:0] addr, input logic [3:0] len);
        if (m == 0) begin
            M0_ARVALID = v; M0_ARID = id; M0_ARADDR = addr; M0_ARLEN = len;
            M0_ARSIZE = v ? 3'b010 : 3'b000; M0_ARBURST = v ? 2'b01 : 2'b00;
        end else begin
            M1_ARVALID = v; M1_ARID = id; M1_ARADDR = addr; M1_ARLEN = len;
            M1_ARSIZE = v ? 3'b010 : 3'b000; M1_ARBURST = v ? 2'b10 : 2'b00;
        end
    endtask

    // Queue the expected beats, then hold ARVALID until accepted
    task automatic ar_issue(input int m, input logic [3:0] id, input logic [31:0] addr,
                            input logic [3:0] len);
        logic done;
        int   n;
        for (int b = 0; b <= int'(len); b++) begin
            if (m == 0) q0.push_back(exp_beat(id, addr, b, len));
            else q1.push_back(exp_beat(id, addr, b, len));
        end
        drive_ar(m, 1'b1, id, addr, len);
        done = 1'b0;
        n = 0;
        while (!done && n < 300) begin
            @(negedge ACLK);
            done = (m == 0) ? M0_ARREADY : M1_ARREADY;
            @(posedge ACLK);
            #1;
            n++;
        end
        drive_ar(m, 1'b0, 4'h0, 32'h0, 4'h0);
        check_eq("ar_accepted", done, 1'b1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while ((GRANT != 2'b00 || q0.size() != 0 || q1.size() != 0) && n < 400);
        check_eq("idle_grant", GRANT, 2'b00);
        check_eq("pending_beats", 64'(q0.size() + q1.size()), 64'd0);
        @(posedge ACLK);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_m0"}, {M0_ARREADY, M0_RID, M0_RRESP, M0_RLAST, M0_RVALID, M0_RDATA},
                 64'd0);
        check_eq({tag, "_m1"}, {M1_ARREADY, M1_RID, M1_RRESP, M1_RLAST, M1_RVALID, M1_RDATA},
                 64'd0);
        check_eq({tag, "_s_ar"}, {S_ARID, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARVALID, S_ARADDR},
                 64'd0);
        check_eq({tag, "_s_r_grant"}, {S_RREADY, GRANT}, 64'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin : stimulus
        logic [31:0] held;
        int          n;
        ARESETn = 1'b0;
        drive_ar(0, 1'b0, 4'h0, 32'h0, 4'h0);
        drive_ar(1, 1'b0, 4'h0, 32'h0, 4'h0);
        M0_RREADY = 1'b1;
        M1_RREADY = 1'b1;
        repeat (3) @(posedge ACLK);
        #1;
        check_outputs_zero("reset");
        ARESETn = 1'b1;
        @(posedge ACLK);
        #1;

        // First tie after reset goes to M0, and so does the next one
        for (int r = 0; r < 2; r++) begin
            gq.push_back(2'b01);
            gq.push_back(2'b10);
            fork
                ar_issue(0, 4'h1, 32'h0000_0100, 4'd3);
                ar_issue(1, 4'h2, 32'h0000_0200, 4'd3);
            join
            wait_idle();
        end

        // Single one-beat read
        gq.push_back(2'b01);
        ar_issue(0, 4'h3, 32'h0000_0010, 4'd0);
        wait_idle();

        // M0 was served last: round-robin hands the tie to M1, fixed priority to M0
        for (int r = 0; r < 3; r++) begin
`ifdef RD_ARB_FIXED_PRIO_EN
            gq.push_back(2'b01);
            gq.push_back(2'b10);
`else
            gq.push_back(2'b10);
            gq.push_back(2'b01);
`endif
            fork
                ar_issue(0, 4'h4, 32'h0000_1000 + 32'(r * 64), 4'd1);
                ar_issue(1, 4'hC, 32'h0000_2000 + 32'(r * 64), 4'd2);
            join
            wait_idle();
        end

        // R back-pressure on M1, with an M0 request raised mid-burst
        M1_RREADY = 1'b0;
        gq.push_back(2'b10);
        gq.push_back(2'b01);
        fork
            ar_issue(1, 4'h5, 32'h0000_0300, 4'd1);
            begin
                n = 0;
                while (!M1_RVALID && n < 50) begin
                    @(negedge ACLK);
                    n++;
                end
                held = beat_data(4'h5, 32'h0000_0300, 0);
                for (int i = 0; i < 5; i++) begin
                    check_eq("bp_rvalid", M1_RVALID, 1'b1);
                    check_eq("bp_s_rready", S_RREADY, 1'b0);
                    check_eq("bp_rdata", M1_RDATA, held);
                    if (i < 4) @(negedge ACLK);
                end
                @(posedge ACLK);
                #1;
                M1_RREADY = 1'b1;
            end
            begin
                n = 0;
                while (GRANT != 2'b10 && n < 50) begin
                    @(negedge ACLK);
                    n++;
                end
                @(posedge ACLK);
                #1;
                ar_issue(0, 4'h6, 32'h0000_0400, 4'd0);
            end
        join
        wait_idle();

        // Slave holds ARREADY low for four cycles
        stall_cfg = 4;
        gq.push_back(2'b01);
        fork
            ar_issue(0, 4'h7, 32'h0000_0500, 4'd2);
            begin
                n = 0;
                while (!S_ARVALID && n < 50) begin
                    @(negedge ACLK);
                    n++;
                end
                for (int i = 0; i < 4; i++) begin
                    check_eq("stall_s_ar", {S_ARVALID, S_ARID, S_ARLEN, S_ARBURST, S_ARADDR},
                             {1'b1, 4'h7, 4'd2, 2'b01, 32'h0000_0500});
                    check_eq("stall_arready", {M0_ARREADY, GRANT}, {1'b0, 2'b01});
                    @(negedge ACLK);
                end
                check_eq("stall_release", M0_ARREADY, 1'b1);
            end
        join
        wait_idle();
        stall_cfg = 0;

        // Reset while beat 2 of an eight-beat burst is on the bus
        gq.push_back(2'b01);
        fork
            ar_issue(0, 4'h8, 32'h0000_0600, 4'd7);
            begin
                n = 0;
                for (int hs = 0; hs < 2 && n < 100; ) begin
                    @(negedge ACLK);
                    n++;
                    if (M0_RVALID && M0_RREADY) hs++;
                end
                @(posedge ACLK);
                #2;
                check_eq("pre_reset_beat2", M0_RDATA, beat_data(4'h8, 32'h0000_0600, 2));
                #1;
                ARESETn = 1'b0;
                #1;
                check_outputs_zero("mid_reset");
                q0.delete();
                repeat (2) @(posedge ACLK);
                #3;
                ARESETn = 1'b1;
            end
        join
        @(posedge ACLK);
        #1;
        gq.push_back(2'b10);
        ar_issue(1, 4'h9, 32'h0000_0700, 4'd2);
        wait_idle();
        check_eq("grant_queue_drained", 64'(gq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter_2to1.md
Name: axi_rd_arbiter_2to1

Overview:
- 2-master to 1-slave AXI read-channel arbiter placed in front of the ROM AXI slave port.
- Lets instruction fetch (M0) and the boot/DMA loader (M1) share the single ROM read port.
- Serialises whole bursts: one AR grant at a time, held until the RLAST beat handshakes.
- Write channels are out of scope.

Parameters:
- ID_BITS, 4, ARID/RID width; passed through unchanged.
- ADDR_BITS, 32, ARADDR width.
- DATA_BITS, 32, RDATA width.
- LEN_BITS, 4, ARLEN width.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- Mx_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  ID_BITS/ADDR_BITS/LEN_BITS/3/2/1  master x AR request (x = 0, 1)
- Mx_ARREADY  out  1  AR accept to master x
- Mx_RID/RDATA/RRESP/RLAST/RVALID  out  ID_BITS/DATA_BITS/2/1/1  R beat to master x
- Mx_RREADY  in  1  master x R accept
- S_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  same widths  AR to ROM slave
- S_ARREADY  in  1  slave AR accept
- S_RID/RDATA/RRESP/RLAST/RVALID  in  same widths  R from slave
- S_RREADY  out  1  R accept to slave
- GRANT  out  2  one-hot current owner, 2'b00 when IDLE

Behaviour:
- Reset: ARESETn is asynchronous, active-low; clock is ACLK.
- Reset state: state=IDLE, last_grant=M1 (so M0 wins the first tie).
- Reset outputs: every output is 0 (all Mx_ARREADY, Mx_RVALID, S_ARVALID, S_RREADY, GRANT, all data/ID fields).
- FSM state IDLE:
  - No ARVALID: stay IDLE.
  - Exactly one Mx_ARVALID: grant x.
  - Both: grant the master != last_grant (round-robin).
  - On a grant: register grant and last_grant, move to ADDR.
  - Arbitration latency is 1 cycle; no slave signal is driven in IDLE.
- FSM state ADDR:
  - S_AR* = granted master's AR* (combinational mux).
  - Granted Mx_ARREADY = S_ARREADY; non-granted ARREADY=0.
  - On S_ARVALID && S_ARREADY, move to DATA.
- FSM state DATA:
  - Granted Mx_R* = S_R*; S_RREADY = granted Mx_RREADY.
  - Non-granted master: RVALID=0, RDATA/RID/RRESP/RLAST=0.
  - S_ARVALID=0.
  - On S_RVALID && S_RREADY && S_RLAST, move to IDLE.
  - Exactly one bubble cycle between bursts.
- Beat counter (LEN_BITS wide):
  - Cleared on entering DATA; increments on each R handshake.
  - Compared with the latched ARLEN for checking only; RLAST from the slave alone ends the burst.
- Granted master drops ARVALID in ADDR before the handshake (protocol violation): hold grant and stay in ADDR. The AXI VALID-stability rule applies, so no recovery path is defined.
- Slave back-pressure:
  - RVALID held with RREADY low: stay in DATA with no timeout (unless the optional feature below is compiled in).
  - ARREADY low: stay in ADDR indefinitely.
- A new ARVALID from the other master during ADDR/DATA: ignored until IDLE; its ARREADY stays 0.
- Reset mid-burst: immediately IDLE, all outputs 0. The slave is reset by the same ARESETn, so no draining.
- GRANT: one-hot of the registered grant in ADDR/DATA, 0 in IDLE.

Optional Feature:
- Macro: RD_ARB_FIXED_PRIO_EN.
- Defined: fixed priority. M0 always wins simultaneous requests; last_grant is unused and may be removed.
- Undefined: round-robin as described in Behaviour.
- Both modes: still one burst at a time, same latency.

Test Plan:
- Single request: M0 ARADDR=0x0000_0010, ARLEN=0; slave returns 0xDEADBEEF with RLAST.
  - M0 sees ARREADY in ADDR, 1 beat of 0xDEADBEEF, RLAST=1.
  - M1 RVALID stays 0; GRANT=01 then 00.
- Simultaneous requests after reset (round-robin build): M0 and M1 ARVALID together, each ARLEN=3.
  - M0 served first (4 beats), bubble, then M1 (4 beats).
  - Next tie goes to M0 again (last_grant=M1).
- Repeated simultaneous requests, 3 rounds, with RD_ARB_FIXED_PRIO_EN defined:
  - M0 granted every round; M1 is granted only when M0 ARVALID=0.
- Back-pressure: M1 burst ARLEN=1, M1 RREADY low for 5 cycles on beat 0.
  - S_RREADY=0 for those 5 cycles; RDATA stable.
  - Burst completes with 2 beats; M0 request raised mid-burst is accepted only after IDLE.
- Slave AR stall: S_ARREADY held low 4 cycles.
  - S_ARVALID and ADDR held stable; state remains ADDR; granted ARREADY=0 until the slave accepts.
- Reset mid-burst: assert ARESETn=0 during beat 2 of an ARLEN=7 burst.
  - All outputs 0 asynchronously; GRANT=00.
  - After release, a new M1 request is served normally.
